// File: rtl/seq_mem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_mem_pkg
// Description : Shared definitions for the sequence-detector data memory
//               write path: default geometry, the counted pattern, the
//               writer FSM state encoding and the per-row match-count width
//               shared with the read-back detector.
// Options     : SEQ_COUNT_EN (consumers only) enables per-row match counting.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mem_pkg;

    localparam int          ADDR_W_DEF  = 5;
    localparam int          ROW_W_DEF   = 16;
    localparam logic [3:0]  PATTERN_DEF = 4'b1011;

    // Writer FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_WRITE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // A row of row_w bits holds at most row_w matches, so the count needs
    // enough bits to represent 0..row_w inclusive.
    function automatic int cnt_width(input int row_w);
        return $clog2(row_w + 1);
    endfunction

    localparam int CNT_W = cnt_width(ROW_W_DEF);

endpackage : seq_mem_pkg
`default_nettype wire

// File: rtl/seq_row_writer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_row_writer_if
// Description : Bus bundle for seq_row_writer: start/config, serial bit
//               stream (ready/valid), row write port and status.
//               master = stimulus/control side, slave = writer.
// Ports       : start, base_addr, num_rows, bit_in, bit_valid  (master->slave)
//               bit_ready, mem_we, mem_addr, mem_wdata, busy, done
//               row_cnt, row_odd (SEQ_COUNT_EN only)         (slave->master)
// Options     : SEQ_COUNT_EN adds row_cnt/row_odd.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_row_writer_if
    import seq_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ROW_W  = ROW_W_DEF
);
    localparam int CW = cnt_width(ROW_W);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_rows;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [ROW_W-1:0]  mem_wdata;
    logic              busy;
    logic              done;
`ifdef SEQ_COUNT_EN
    logic [CW-1:0]     row_cnt;
    logic              row_odd;
`endif

    modport master (
        output start, base_addr, num_rows, bit_in, bit_valid,
        input  bit_ready, mem_we, mem_addr, mem_wdata, busy, done
`ifdef SEQ_COUNT_EN
        , input row_cnt, row_odd
`endif
    );

    modport slave (
        input  start, base_addr, num_rows, bit_in, bit_valid,
        output bit_ready, mem_we, mem_addr, mem_wdata, busy, done
`ifdef SEQ_COUNT_EN
        , output row_cnt, row_odd
`endif
    );

endinterface : seq_row_writer_if
`default_nettype wire

// File: rtl/seq_row_writer_match.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_match_counter
// Description : Counts overlapping 4-bit PATTERN matches within one row of
//               a serial MSB-first stream. The window restarts at every row
//               so matches never span rows; the final count of a row is
//               latched on its last bit and held until the next row ends.
// Ports       : clk, rst     clock, synchronous active-high reset
//               clr_i        row start (new transfer), clears the window
//               step_i       one accepted bit this cycle
//               bit_i        the accepted bit
//               last_i       the accepted bit completes the row
//               row_cnt_o    matches in the last completed row
//               row_odd_o    row_cnt_o[0]
// Options     : only instantiated when SEQ_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_counter
    import seq_mem_pkg::*;
#(
    parameter int         ROW_W   = ROW_W_DEF,
    parameter logic [3:0] PATTERN = PATTERN_DEF
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        step_i,
    input  logic                        bit_i,
    input  logic                        last_i,
    output logic [cnt_width(ROW_W)-1:0] row_cnt_o,
    output logic                        row_odd_o
);
    localparam int CW = cnt_width(ROW_W);

    logic [2:0]    win_q;   // previous three bits of the current row
    logic [1:0]    fill_q;  // how many of win_q belong to this row (sat. 3)
    logic [CW-1:0] cnt_q;   // running count for the current row
    logic [CW-1:0] held_q;  // count of the last completed row
    logic          w_hit;
    logic [CW-1:0] cnt_d;

    // Only a full window of this row's own bits may match, which keeps the
    // cleared window from producing matches for patterns with leading zeros.
    assign w_hit = step_i && (fill_q == 2'd3) && ({win_q, bit_i} == PATTERN);
    assign cnt_d = cnt_q + {{(CW-1){1'b0}}, w_hit};

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            held_q <= '0;
        end else if (clr_i) begin
            win_q  <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else if (step_i) begin
            if (last_i) begin
                held_q <= cnt_d;
                win_q  <= '0;
                fill_q <= '0;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_d;
                win_q  <= {win_q[1:0], bit_i};
                fill_q <= (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
            end
        end
    end

    assign row_cnt_o = held_q;
    assign row_odd_o = held_q[0];

endmodule : seq_match_counter
`default_nettype wire

// File: rtl/seq_row_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seq_row_writer
// Description : Write side of the sequence-detector data memory. Packs a
//               serial ready/valid bit stream MSB-first into ROW_W-bit rows
//               and writes num_rows rows upward from base_addr (address
//               wraps modulo 2**ADDR_W). FSM: IDLE -> SHIFT -> WRITE ->
//               (SHIFT | DONE) -> IDLE.
// Ports       : clk, rst  clock, synchronous active-high reset
//               bus       seq_row_writer_if.slave (start/config, bit stream,
//                         row write port, busy/done, optional row stats)
// Options     : SEQ_COUNT_EN adds per-row PATTERN match count (row_cnt)
//               and parity (row_odd), valid with mem_we.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_row_writer
    import seq_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ROW_W  = ROW_W_DEF
`ifdef SEQ_COUNT_EN
    ,
    parameter logic [3:0] PATTERN = PATTERN_DEF
`endif
)(
    input  logic              clk,
    input  logic              rst,
    seq_row_writer_if.slave   bus
);
    localparam int                BC_W        = $clog2(ROW_W);
    localparam logic [BC_W-1:0]   c_LAST_BIT  = BC_W'(ROW_W - 1);
    localparam logic [ADDR_W:0]   c_ONE_ROW   = (ADDR_W+1)'(1);

    state_t            state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [ADDR_W:0]   rows_q,   rows_d;    // rows still to be written
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;  // bits accepted in current row
    logic [ROW_W-1:0]  row_q,    row_d;

    logic w_start;
    logic w_accept;
    logic w_last;
    logic w_we;

    assign w_start  = (state_q == ST_IDLE) && bus.start;
    assign w_accept = (state_q == ST_SHIFT) && bus.bit_valid;
    assign w_last   = w_accept && (bitcnt_q == c_LAST_BIT);
    assign w_we     = (state_q == ST_WRITE);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rows_d   = rows_q;
        bitcnt_d = bitcnt_q;
        row_d    = row_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.base_addr;
                    rows_d   = bus.num_rows;
                    bitcnt_d = '0;
                    row_d    = '0;
                    state_d  = (bus.num_rows == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_accept) begin
                    row_d    = {row_q[ROW_W-2:0], bus.bit_in};
                    bitcnt_d = w_last ? '0 : bitcnt_q + 1'b1;
                    if (w_last) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // Address increment wraps naturally at 2**ADDR_W.
                addr_d  = addr_q + 1'b1;
                rows_d  = rows_q - 1'b1;
                state_d = (rows_q == c_ONE_ROW) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rows_q   <= '0;
            bitcnt_q <= '0;
            row_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rows_q   <= rows_d;
            bitcnt_q <= bitcnt_d;
            row_q    <= row_d;
        end
    end

    // All outputs decode from registered state, so they are 0 the cycle
    // after reset and glitch-free with respect to the inputs.
    assign bus.bit_ready = (state_q == ST_SHIFT);
    assign bus.mem_we    = w_we;
    assign bus.mem_addr  = w_we ? addr_q : '0;
    assign bus.mem_wdata = w_we ? row_q  : '0;
    assign bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_WRITE);
    assign bus.done      = (state_q == ST_DONE);

`ifdef SEQ_COUNT_EN
    seq_match_counter #(
        .ROW_W   (ROW_W),
        .PATTERN (PATTERN)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (w_start),
        .step_i    (w_accept),
        .bit_i     (bus.bit_in),
        .last_i    (w_last),
        .row_cnt_o (bus.row_cnt),
        .row_odd_o (bus.row_odd)
    );
`endif

endmodule : seq_row_writer
`default_nettype wire

// File: tb/tb_seq_row_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seq_row_writer
// Description : Directed self-checking bench for seq_row_writer: reset,
//               single row, zero row, address wrap, gapped stream with a
//               stray start, zero-row request and mid-row reset abort.
// Options     : SEQ_COUNT_EN also checks row_cnt/row_odd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_row_writer;
    import seq_mem_pkg::*;

    localparam int AW = 5;
    localparam int RW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_row_writer_if #(.ADDR_W(AW), .ROW_W(RW)) bus ();

    seq_row_writer #(.ADDR_W(AW), .ROW_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [AW-1:0] wa[$];
    logic [RW-1:0] wd[$];
    int            wc[$];
`ifdef SEQ_COUNT_EN
    logic [4:0]    wcnt[$];
    logic          wodd[$];
`endif
    int done_n;
    int done_c;
    bit busy_seen;
    int last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/status monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
            wc.push_back(cyc);
`ifdef SEQ_COUNT_EN
            wcnt.push_back(bus.row_cnt);
            wodd.push_back(bus.row_odd);
`endif
        end
        if (bus.done) begin
            done_n = done_n + 1;
            done_c = cyc;
        end
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        wc.delete();
`ifdef SEQ_COUNT_EN
        wcnt.delete();
        wodd.delete();
`endif
        done_n    = 0;
        done_c    = -1;
        busy_seen = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] num,
                            output int sc);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.num_rows  = num;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        sc            = cyc;
    endtask

    task automatic send_bits(input int nbits, input logic [RW-1:0] r0,
                             input logic [RW-1:0] r1, input bit gappy,
                             input bit poke);
        int b = 0;
        int guard = 0;
        logic [RW-1:0] cur;
        logic acc;
        while (b < nbits && guard < 2000) begin
            cur           = (b < RW) ? r0 : r1;
            bus.bit_valid = gappy ? ((guard % 2) == 0) : 1'b1;
            bus.bit_in    = cur[RW-1-(b % RW)];
            bus.start     = poke && (guard == 5);
            bus.base_addr = 5'd20;
            bus.num_rows  = 6'd3;
            acc           = bus.bit_valid && bus.bit_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                b++;
                last_cyc = cyc;
            end
        end
        bus.bit_valid = 1'b0;
        bus.start     = 1'b0;
        checks++;
        if (b != nbits) begin
            errors++;
            $display("FAIL send_bits_timeout: accepted %0d bits, expected %0d", b, nbits);
        end
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_n == 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (done_n == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done pulse, expected one", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_rows = '0;
        bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.bit_ready, bus.mem_we, bus.busy, bus.done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 0000",
                     {bus.bit_ready, bus.mem_we, bus.busy, bus.done});
        end
        checks++;
        if (bus.mem_addr !== 5'd0 || bus.mem_wdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bus: got addr %h data %h, expected 00 0000",
                     bus.mem_addr, bus.mem_wdata);
        end
`ifdef SEQ_COUNT_EN
        checks++;
        if (bus.row_cnt !== 5'd0 || bus.row_odd !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%b, expected 0/0", bus.row_cnt, bus.row_odd);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_row();
        int sc;
        clear_mon();
        do_start(5'd15, 6'd1, sc);
        send_bits(16, 16'h0000, 16'h0000, 1'b0, 1'b0);
        wait_done("zero_row");
        checks++;
        if (wa.size() != 1 || wa[0] !== 5'd15 || wd[0] !== 16'h0000) begin
            errors++;
            $display("FAIL zero_row_write: got n=%0d addr %h data %h, expected n=1 addr 0f data 0000",
                     wa.size(), wa[0], wd[0]);
        end
`ifdef SEQ_COUNT_EN
        checks++;
        if (wcnt[0] !== 5'd0 || wodd[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_row_cnt: got %0d/%b, expected 0/0", wcnt[0], wodd[0]);
        end
`endif
    endtask

    task automatic test_wrap();
        int sc;
        clear_mon();
        do_start(5'd31, 6'd2, sc);
        send_bits(32, 16'hB000, 16'h1234, 1'b0, 1'b0);
        wait_done("wrap");
        checks++;
        if (wa.size() != 2 || wa[0] !== 5'd31 || wa[1] !== 5'd0) begin
            errors++;
            $display("FAIL wrap_addr: got n=%0d %h,%h, expected n=2 1f,00",
                     wa.size(), wa[0], wa[1]);
        end
        checks++;
        if (wd[0] !== 16'hB000 || wd[1] !== 16'h1234) begin
            errors++;
            $display("FAIL wrap_data: got %h,%h, expected b000,1234", wd[0], wd[1]);
        end
`ifdef SEQ_COUNT_EN
        checks++;
        if (wcnt[0] !== 5'd1 || wodd[0] !== 1'b1 || wcnt[1] !== 5'd0 || wodd[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_cnt: got %0d/%b,%0d/%b, expected 1/1,0/0",
                     wcnt[0], wodd[0], wcnt[1], wodd[1]);
        end
`endif
    endtask

    task automatic test_gaps();
        int sc;
        clear_mon();
        do_start(5'd4, 6'd2, sc);
        send_bits(32, 16'hB600, 16'h00FF, 1'b1, 1'b1);
        wait_done("gaps");
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (wa.size() != 2 || wa[0] !== 5'd4 || wa[1] !== 5'd5) begin
            errors++;
            $display("FAIL gaps_addr: got n=%0d %h,%h, expected n=2 04,05",
                     wa.size(), wa[0], wa[1]);
        end
        checks++;
        if (wd[0] !== 16'hB600 || wd[1] !== 16'h00FF) begin
            errors++;
            $display("FAIL gaps_data: got %h,%h, expected b600,00ff", wd[0], wd[1]);
        end
        checks++;
        if (done_n != 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_single_xfer: got done=%0d busy=%b, expected 1 0",
                     done_n, bus.busy);
        end
    endtask

    task automatic test_zero_rows();
        int sc;
        clear_mon();
        do_start(5'd10, 6'd0, sc);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wa.size() != 0 || done_n != 1 || done_c != sc) begin
            errors++;
            $display("FAIL zero_rows: got writes=%0d done=%0d at %0d, expected 0 1 at %0d",
                     wa.size(), done_n, done_c, sc);
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL zero_rows_busy: got busy seen %b, expected 0", busy_seen);
        end
    endtask

    task automatic test_single_row();
        int sc;
        clear_mon();
        do_start(5'd3, 6'd1, sc);
        checks++;
        if (bus.busy !== 1'b1 || bus.bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got busy=%b ready=%b, expected 1 1",
                     bus.busy, bus.bit_ready);
        end
        send_bits(16, 16'hB600, 16'h0000, 1'b0, 1'b0);
        wait_done("single");
        checks++;
        if (wa.size() != 1 || wa[0] !== 5'd3 || wd[0] !== 16'hB600) begin
            errors++;
            $display("FAIL single_write: got n=%0d addr %h data %h, expected n=1 addr 03 data b600",
                     wa.size(), wa[0], wd[0]);
        end
        checks++;
        if (wc[0] != last_cyc || done_c != last_cyc + 1) begin
            errors++;
            $display("FAIL single_latency: got we@%0d done@%0d, expected we@%0d done@%0d",
                     wc[0], done_c, last_cyc, last_cyc + 1);
        end
`ifdef SEQ_COUNT_EN
        checks++;
        if (wcnt[0] !== 5'd2 || wodd[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_cnt: got %0d/%b, expected 2/0", wcnt[0], wodd[0]);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int sc;
        clear_mon();
        do_start(5'd7, 6'd1, sc);
        send_bits(9, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.bit_ready, bus.mem_we, bus.busy, bus.done} !== 4'b0000 ||
            bus.mem_addr !== 5'd0 || bus.mem_wdata !== 16'h0000) begin
            errors++;
            $display("FAIL abort_outputs: got ctl %b addr %h data %h, expected 0000 00 0000",
                     {bus.bit_ready, bus.mem_we, bus.busy, bus.done}, bus.mem_addr, bus.mem_wdata);
        end
`ifdef SEQ_COUNT_EN
        checks++;
        if (bus.row_cnt !== 5'd0 || bus.row_odd !== 1'b0) begin
            errors++;
            $display("FAIL abort_cnt: got %0d/%b, expected 0/0", bus.row_cnt, bus.row_odd);
        end
`endif
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wa.size() != 0 || done_n != 0) begin
            errors++;
            $display("FAIL abort_no_write: got writes=%0d done=%0d, expected 0 0",
                     wa.size(), done_n);
        end
        clear_mon();
        do_start(5'd9, 6'd1, sc);
        send_bits(16, 16'hA5C3, 16'h0000, 1'b0, 1'b0);
        wait_done("after_abort");
        checks++;
        if (wa.size() != 1 || wa[0] !== 5'd9 || wd[0] !== 16'hA5C3) begin
            errors++;
            $display("FAIL after_abort_write: got n=%0d addr %h data %h, expected n=1 addr 09 data a5c3",
                     wa.size(), wa[0], wd[0]);
        end
`ifdef SEQ_COUNT_EN
        checks++;
        if (wcnt[0] !== 5'd1 || wodd[0] !== 1'b1) begin
            errors++;
            $display("FAIL after_abort_cnt: got %0d/%b, expected 1/1", wcnt[0], wodd[0]);
        end
`endif
    endtask

    initial begin
        clear_mon();
        last_cyc = 0;
        test_reset();
        test_zero_row();
        test_wrap();
        test_gaps();
        test_zero_rows();
        test_single_row();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_row_writer
`default_nettype wire
